alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares the single execute-stage ALU between two requesters: R0 is the integer pipe and R1 is the address/branch helper.
- Accepts one operation per cycle from a valid/ready request channel and drives the ALU's operand and control inputs.
- Captures the ALU result in a per-requester one-entry response buffer, returned over a valid/ready response channel.
- The ALU stays an external instance; the arbiter connects to its A, B, ALU_CONTROL and OUT pins.

Parameters:
- WIDTH, 32 (`INST_SIZE`): operand/result width.
- CNT_WIDTH, 16: width of the statistics counters (used only with the optional feature).

Ports:
- CLK  in  1  clock.
- RESET  in  1  asynchronous, active-high reset.
- REQ0_VALID  in  1  R0 request valid.
- REQ0_READY  out  1  R0 request accepted this cycle.
- REQ0_A  in  WIDTH  R0 operand A.
- REQ0_B  in  WIDTH  R0 operand B.
- REQ0_OP  in  3  R0 ALU op (`ALU_ADD/SUB/AND/OR/XOR`).
- REQ1_VALID, REQ1_READY, REQ1_A, REQ1_B, REQ1_OP: same as the R0 request ports, for R1.
- RSP0_VALID  out  1  R0 result valid.
- RSP0_READY  in  1  R0 consumer ready.
- RSP0_DATA  out  WIDTH  R0 result.
- RSP1_VALID, RSP1_READY, RSP1_DATA: same as the R0 response ports, for R1.
- ALU_A  out  WIDTH  to ALU A.
- ALU_B  out  WIDTH  to ALU B.
- ALU_CONTROL  out  3  to ALU ALU_CONTROL.
- ALU_OUT  in  WIDTH  from ALU OUT.

Behaviour:
- Reset: asynchronous, active-high. Clears RSP0_VALID, RSP1_VALID, RSP0_DATA, RSP1_DATA and the stats counters to 0. Sets LAST_GRANT=1, so R0 wins the first contention.
- Eligibility: requester x is eligible when REQx_VALID=1 and (RSPx_VALID=0 or RSPx_READY=1). A full buffer being drained in the same cycle counts as free.
- Arbitration (combinational, same cycle):
  - Exactly one eligible requester: it is granted.
  - Both eligible: the requester with id != LAST_GRANT is granted (round-robin).
  - None eligible: no grant.
- REQx_READY = grant to x. A requester is never ready in a cycle in which it is not granted.
- ALU drive:
  - On a grant, ALU_A/ALU_B/ALU_CONTROL = the granted requester's A/B/OP.
  - With no grant, all three are driven to 0 (ALU_CONTROL=0); ALU_OUT is ignored.
- Capture: at the rising edge of a grant cycle, RSPx_DATA<=ALU_OUT, RSPx_VALID<=1, LAST_GRANT<=x. Latency is exactly 1 cycle: accepted at edge N, result visible after edge N.
- Response handshake:
  - Transfer occurs when RSPx_VALID & RSPx_READY.
  - After a transfer with no new grant to x, RSPx_VALID<=0. RSPx_DATA holds its value; it is don't-care while invalid.
  - While RSPx_VALID=1 and RSPx_READY=0, RSPx_DATA is held stable.
- Simultaneous events:
  - Drain and new capture on the same edge for x: the new data wins and RSPx_VALID stays 1, giving full throughput of 1 op/cycle per requester.
  - R0 stalled (buffer full, RSP0_READY=0) while R1 is eligible: R1 is granted every cycle; there is no bubble and no starvation of R1.
- Undefined REQx_OP encodings are forwarded unchanged; the result is whatever the ALU returns (all zeros). There is no error flag.
- Request operands need not be stable when not granted; they are sampled only in the grant cycle.
- Reset mid-operation: pending response data is discarded and LAST_GRANT returns to 1. No grant is issued while RESET=1.

Optional Feature:
- Macro: ALU_ARBITER_STATS_EN.
- Defined:
  - Adds outputs GRANT_CNT0 and GRANT_CNT1 (CNT_WIDTH each) and CONTENTION_CNT (CNT_WIDTH).
  - GRANT_CNTx increments on each grant to x.
  - CONTENTION_CNT increments in each cycle where both requesters are eligible.
  - All three saturate at all-ones and reset to 0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Single R0: R0 ADD A=5, B=7 with RSP0_READY=1 -> REQ0_READY=1 the same cycle; RSP0_VALID=1 with RSP0_DATA=12 the next cycle; R1 untouched.
- Round-robin contention: both valid for 4 cycles (R0 SUB 10-3, R1 XOR 0xF0^0x0F) with both RSP ready -> grants R0,R1,R0,R1; results 7 and 0xFF each alternate cycle.
- Backpressure on R0:
  - R0 issues AND 0xFF00&0x0FF0 and gets a result, with RSP0_READY=0 for 3 cycles; R0 keeps a second request valid.
  - Required: RSP0_DATA stays 0x0F00, REQ0_READY=0, and R1 requests are granted every cycle.
  - Raise RSP0_READY -> the second R0 request is accepted that same cycle.
- Streaming drain+capture: R0 back-to-back OR ops for 8 cycles with RSP0_READY=1 -> REQ0_READY=1 every cycle and RSP0_VALID continuously 1 with the correct data each cycle.
- Reset mid-op: assert RESET asynchronously while RSP1_VALID=1 -> RSP1_VALID=0 immediately. After release, simultaneous requests grant R0 first.
- Stats (ALU_ARBITER_STATS_EN, CNT_WIDTH=4): 20 contended cycles -> GRANT_CNT0=10, GRANT_CNT1=10, CONTENTION_CNT=15 (saturated).

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one execute-stage ALU between the integer pipe (R0)
// and the address/branch helper (R1). Optional grant/contention counters: ALU_ARBITER_STATS_EN.

module alu_arbiter_rsp #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             grant,
  input  logic             rsp_ready,
  input  logic [WIDTH-1:0] alu_out,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_data
);
  logic             valid_d, valid_q;
  logic [WIDTH-1:0] data_d, data_q;

  // A capture on the drain edge keeps valid high, giving 1 op/cycle throughput.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (grant) begin
      valid_d = 1'b1;
      data_d  = alu_out;
    end else if (valid_q && rsp_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign rsp_valid = valid_q;
  assign rsp_data  = data_q;
endmodule

module alu_arbiter #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 REQ0_VALID,
  output logic                 REQ0_READY,
  input  logic [WIDTH-1:0]     REQ0_A,
  input  logic [WIDTH-1:0]     REQ0_B,
  input  logic [2:0]           REQ0_OP,
  input  logic                 REQ1_VALID,
  output logic                 REQ1_READY,
  input  logic [WIDTH-1:0]     REQ1_A,
  input  logic [WIDTH-1:0]     REQ1_B,
  input  logic [2:0]           REQ1_OP,
  output logic                 RSP0_VALID,
  input  logic                 RSP0_READY,
  output logic [WIDTH-1:0]     RSP0_DATA,
  output logic                 RSP1_VALID,
  input  logic                 RSP1_READY,
  output logic [WIDTH-1:0]     RSP1_DATA,
  output logic [WIDTH-1:0]     ALU_A,
  output logic [WIDTH-1:0]     ALU_B,
  output logic [2:0]           ALU_CONTROL,
  input  logic [WIDTH-1:0]     ALU_OUT
`ifdef ALU_ARBITER_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0] GRANT_CNT0,
  output logic [CNT_WIDTH-1:0] GRANT_CNT1,
  output logic [CNT_WIDTH-1:0] CONTENTION_CNT
`endif
);
  localparam int NUM_REQ = 2;

  logic [NUM_REQ-1:0]            req_valid, rsp_ready, rsp_valid, elig, grant;
  logic [NUM_REQ-1:0][WIDTH-1:0] req_a, req_b, rsp_data;
  logic [NUM_REQ-1:0][2:0]       req_op;
  logic                          last_grant_d, last_grant_q;

  assign req_valid = {REQ1_VALID, REQ0_VALID};
  assign rsp_ready = {RSP1_READY, RSP0_READY};
  assign req_a     = {REQ1_A, REQ0_A};
  assign req_b     = {REQ1_B, REQ0_B};
  assign req_op    = {REQ1_OP, REQ0_OP};

  genvar g;
  generate
    for (g = 0; g < NUM_REQ; g++) begin : g_req
      // A full buffer being drained this cycle counts as free.
      assign elig[g] = req_valid[g] & (~rsp_valid[g] | rsp_ready[g]);

      alu_arbiter_rsp #(.WIDTH(WIDTH)) u_rsp (
        .clk      (CLK),
        .rst      (RESET),
        .grant    (grant[g]),
        .rsp_ready(rsp_ready[g]),
        .alu_out  (ALU_OUT),
        .rsp_valid(rsp_valid[g]),
        .rsp_data (rsp_data[g])
      );
    end
  endgenerate

  always_comb begin
    grant = '0;
    if (!RESET) begin
      if (&elig) grant = last_grant_q ? 2'b01 : 2'b10;
      else       grant = elig;
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (grant[1])      last_grant_d = 1'b1;
    else if (grant[0]) last_grant_d = 1'b0;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) last_grant_q <= 1'b1;
    else       last_grant_q <= last_grant_d;
  end

  // Idle ALU inputs are held at zero so the shared ALU sees no stale operands.
  always_comb begin
    ALU_A       = '0;
    ALU_B       = '0;
    ALU_CONTROL = '0;
    if (grant[0]) begin
      ALU_A       = req_a[0];
      ALU_B       = req_b[0];
      ALU_CONTROL = req_op[0];
    end else if (grant[1]) begin
      ALU_A       = req_a[1];
      ALU_B       = req_b[1];
      ALU_CONTROL = req_op[1];
    end
  end

  assign REQ0_READY = grant[0];
  assign REQ1_READY = grant[1];
  assign RSP0_VALID = rsp_valid[0];
  assign RSP1_VALID = rsp_valid[1];
  assign RSP0_DATA  = rsp_data[0];
  assign RSP1_DATA  = rsp_data[1];

`ifdef ALU_ARBITER_STATS_EN
  logic [CNT_WIDTH-1:0] gcnt0_d, gcnt0_q, gcnt1_d, gcnt1_q, ccnt_d, ccnt_q;

  // Saturating counters: stop at all-ones.
  always_comb begin
    gcnt0_d = gcnt0_q;
    gcnt1_d = gcnt1_q;
    ccnt_d  = ccnt_q;
    if (grant[0] && !(&gcnt0_q)) gcnt0_d = gcnt0_q + 1'b1;
    if (grant[1] && !(&gcnt1_q)) gcnt1_d = gcnt1_q + 1'b1;
    if ((&elig) && !(&ccnt_q))   ccnt_d  = ccnt_q + 1'b1;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      gcnt0_q <= '0;
      gcnt1_q <= '0;
      ccnt_q  <= '0;
    end else begin
      gcnt0_q <= gcnt0_d;
      gcnt1_q <= gcnt1_d;
      ccnt_q  <= ccnt_d;
    end
  end

  assign GRANT_CNT0     = gcnt0_q;
  assign GRANT_CNT1     = gcnt1_q;
  assign CONTENTION_CNT = ccnt_q;
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed, table-driven bench for alu_arbiter with a behavioural ALU model on the ALU pins.

module tb_alu_arbiter;
  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR = 3'd3, OP_XOR = 3'd4;
`ifdef ALU_ARBITER_STATS_EN
  localparam int CW = 4;
`else
  localparam int CW = 16;
`endif

  logic        CLK, RESET;
  logic        REQ0_VALID, REQ0_READY, REQ1_VALID, REQ1_READY;
  logic [31:0] REQ0_A, REQ0_B, REQ1_A, REQ1_B;
  logic [2:0]  REQ0_OP, REQ1_OP;
  logic        RSP0_VALID, RSP0_READY, RSP1_VALID, RSP1_READY;
  logic [31:0] RSP0_DATA, RSP1_DATA;
  logic [31:0] ALU_A, ALU_B, ALU_OUT;
  logic [2:0]  ALU_CONTROL;
`ifdef ALU_ARBITER_STATS_EN
  logic [CW-1:0] GRANT_CNT0, GRANT_CNT1, CONTENTION_CNT;
`endif

  int checks = 0;
  int fails  = 0;

  alu_arbiter #(.WIDTH(32), .CNT_WIDTH(CW)) dut (
    .CLK(CLK), .RESET(RESET),
    .REQ0_VALID(REQ0_VALID), .REQ0_READY(REQ0_READY), .REQ0_A(REQ0_A), .REQ0_B(REQ0_B), .REQ0_OP(REQ0_OP),
    .REQ1_VALID(REQ1_VALID), .REQ1_READY(REQ1_READY), .REQ1_A(REQ1_A), .REQ1_B(REQ1_B), .REQ1_OP(REQ1_OP),
    .RSP0_VALID(RSP0_VALID), .RSP0_READY(RSP0_READY), .RSP0_DATA(RSP0_DATA),
    .RSP1_VALID(RSP1_VALID), .RSP1_READY(RSP1_READY), .RSP1_DATA(RSP1_DATA),
    .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_CONTROL(ALU_CONTROL), .ALU_OUT(ALU_OUT)
`ifdef ALU_ARBITER_STATS_EN
    , .GRANT_CNT0(GRANT_CNT0), .GRANT_CNT1(GRANT_CNT1), .CONTENTION_CNT(CONTENTION_CNT)
`endif
  );

  // External ALU: undefined encodings return zero.
  always_comb begin
    case (ALU_CONTROL)
      OP_ADD:  ALU_OUT = ALU_A + ALU_B;
      OP_SUB:  ALU_OUT = ALU_A - ALU_B;
      OP_AND:  ALU_OUT = ALU_A & ALU_B;
      OP_OR:   ALU_OUT = ALU_A | ALU_B;
      OP_XOR:  ALU_OUT = ALU_A ^ ALU_B;
      default: ALU_OUT = '0;
    endcase
  end

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic        v0; logic [31:0] a0, b0; logic [2:0] op0;
    logic        v1; logic [31:0] a1, b1; logic [2:0] op1;
    logic        rr0, rr1;
    logic        rdy0, rdy1;
    logic        rv0; logic [31:0] rd0;
    logic        rv1; logic [31:0] rd1;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic v0, logic [31:0] a0, logic [31:0] b0, logic [2:0] op0,
                              logic v1, logic [31:0] a1, logic [31:0] b1, logic [2:0] op1,
                              logic rr0, logic rr1, logic rdy0, logic rdy1,
                              logic rv0, logic [31:0] rd0, logic rv1, logic [31:0] rd1);
    vec_t t;
    t.v0 = v0; t.a0 = a0; t.b0 = b0; t.op0 = op0;
    t.v1 = v1; t.a1 = a1; t.b1 = b1; t.op1 = op1;
    t.rr0 = rr0; t.rr1 = rr1; t.rdy0 = rdy0; t.rdy1 = rdy1;
    t.rv0 = rv0; t.rd0 = rd0; t.rv1 = rv1; t.rd1 = rd1;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    REQ0_VALID = t.v0; REQ0_A = t.a0; REQ0_B = t.b0; REQ0_OP = t.op0;
    REQ1_VALID = t.v1; REQ1_A = t.a1; REQ1_B = t.b1; REQ1_OP = t.op1;
    RSP0_READY = t.rr0; RSP1_READY = t.rr1;
  endtask

  vec_t idle;

  initial begin
    idle = mk(0,0,0,0, 0,0,0,0, 1,1, 0,0, 0,0,0,0);
    // Single R0 ADD, then idle drain
    tbl.push_back(mk(1,5,7,OP_ADD,       0,0,0,0,          1,1, 1,0, 1,12,  0,0));
    tbl.push_back(mk(0,0,0,0,            0,0,0,0,          1,1, 0,0, 0,12,  0,0));
    // R1 op so LAST_GRANT=1 before contention
    tbl.push_back(mk(0,0,0,0,            1,1,1,OP_ADD,     1,1, 0,1, 0,12,  1,2));
    // Round-robin: R0,R1,R0,R1
    tbl.push_back(mk(1,10,3,OP_SUB,      1,32'hF0,32'h0F,OP_XOR, 1,1, 1,0, 1,7, 0,2));
    tbl.push_back(mk(1,10,3,OP_SUB,      1,32'hF0,32'h0F,OP_XOR, 1,1, 0,1, 0,7, 1,32'hFF));
    tbl.push_back(mk(1,10,3,OP_SUB,      1,32'hF0,32'h0F,OP_XOR, 1,1, 1,0, 1,7, 0,32'hFF));
    tbl.push_back(mk(1,10,3,OP_SUB,      1,32'hF0,32'h0F,OP_XOR, 1,1, 0,1, 0,7, 1,32'hFF));
    // Backpressure on R0: capture 0x0F00, then stall 3 cycles while R1 streams
    tbl.push_back(mk(1,32'hFF00,32'h0FF0,OP_AND, 0,0,0,0,  0,1, 1,0, 1,32'h0F00, 0,32'hFF));
    tbl.push_back(mk(1,32'h1234,32'hFFFF,OP_AND, 1,2,3,OP_ADD,   0,1, 0,1, 1,32'h0F00, 1,5));
    tbl.push_back(mk(1,32'h1234,32'hFFFF,OP_AND, 1,4,4,OP_ADD,   0,1, 0,1, 1,32'h0F00, 1,8));
    tbl.push_back(mk(1,32'h1234,32'hFFFF,OP_AND, 1,10,20,OP_ADD, 0,1, 0,1, 1,32'h0F00, 1,30));
    // Drain opens: second R0 request accepted same cycle
    tbl.push_back(mk(1,32'h1234,32'hFFFF,OP_AND, 1,1,2,OP_ADD,   1,1, 1,0, 1,32'h1234, 0,30));
    // Streaming OR: drain + capture every cycle
    for (int i = 1; i <= 8; i++)
      tbl.push_back(mk(1,i<<4,i,OP_OR, 0,0,0,0, 1,1, 1,0, 1,(i<<4)|i, 0,30));
    // Undefined op forwarded, ALU returns zero
    tbl.push_back(mk(0,0,0,0,            1,5,5,3'd7,       1,1, 0,1, 0,32'h88, 1,0));
    // R1 full and not ready: not eligible, data held
    tbl.push_back(mk(0,0,0,0,            1,1,1,OP_ADD,     1,0, 0,0, 0,32'h88, 1,0));

    drive(idle);
    RESET = 1'b1;
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;
    chk("reset rsp0_valid", {31'd0, RSP0_VALID}, 0);
    chk("reset rsp1_valid", {31'd0, RSP1_VALID}, 0);
    chk("reset rsp0_data", RSP0_DATA, 0);
    chk("reset rsp1_data", RSP1_DATA, 0);

    foreach (tbl[i]) begin
      drive(tbl[i]);
      #4;
      chk($sformatf("row%0d req0_ready", i), {31'd0, REQ0_READY}, {31'd0, tbl[i].rdy0});
      chk($sformatf("row%0d req1_ready", i), {31'd0, REQ1_READY}, {31'd0, tbl[i].rdy1});
      @(posedge CLK);
      #1;
      chk($sformatf("row%0d rsp0_valid", i), {31'd0, RSP0_VALID}, {31'd0, tbl[i].rv0});
      chk($sformatf("row%0d rsp1_valid", i), {31'd0, RSP1_VALID}, {31'd0, tbl[i].rv1});
      if (tbl[i].rv0) chk($sformatf("row%0d rsp0_data", i), RSP0_DATA, tbl[i].rd0);
      if (tbl[i].rv1) chk($sformatf("row%0d rsp1_data", i), RSP1_DATA, tbl[i].rd1);
    end

    // No grant: ALU inputs forced to zero even with operands present
    REQ0_VALID = 1'b0; REQ0_A = 32'hDEAD; REQ0_B = 32'hBEEF; REQ0_OP = OP_XOR;
    #1;
    chk("idle alu_a", ALU_A, 0);
    chk("idle alu_b", ALU_B, 0);
    chk("idle alu_ctl", {29'd0, ALU_CONTROL}, 0);

    // Async reset mid-op while RSP1_VALID=1
    chk("pre-reset rsp1_valid", {31'd0, RSP1_VALID}, 1);
    RESET = 1'b1;
    #1;
    chk("async reset rsp1_valid", {31'd0, RSP1_VALID}, 0);
    REQ0_VALID = 1'b1; REQ0_A = 2; REQ0_B = 2; REQ0_OP = OP_ADD;
    REQ1_VALID = 1'b1; REQ1_A = 9; REQ1_B = 1; REQ1_OP = OP_SUB;
    RSP0_READY = 1'b1; RSP1_READY = 1'b1;
    #1;
    chk("reset no grant r0", {31'd0, REQ0_READY}, 0);
    chk("reset no grant r1", {31'd0, REQ1_READY}, 0);
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    chk("post-reset grant r0", {31'd0, REQ0_READY}, 1);
    chk("post-reset grant r1", {31'd0, REQ1_READY}, 0);
    @(posedge CLK);
    #1;
    chk("post-reset rsp0_valid", {31'd0, RSP0_VALID}, 1);
    chk("post-reset rsp0_data", RSP0_DATA, 4);
    #4;
    chk("post-reset rr grant r1", {31'd0, REQ1_READY}, 1);

`ifdef ALU_ARBITER_STATS_EN
    RESET = 1'b1;
    #1;
    chk("stats reset cnt0", {28'd0, GRANT_CNT0}, 0);
    @(negedge CLK);
    RESET = 1'b0;
    repeat (20) @(posedge CLK);
    #1;
    REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
    chk("stats grant_cnt0", {28'd0, GRANT_CNT0}, 10);
    chk("stats grant_cnt1", {28'd0, GRANT_CNT1}, 10);
    chk("stats contention_cnt", {28'd0, CONTENTION_CNT}, 15);
`endif

    drive(idle);
    @(posedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach summary");
    $fatal(1);
  end
endmodule
